instr_register_scheduler: RTL and testbench
===========================================

# instr_register_scheduler

Write-side arbiter and read-side sequencer for the 32-entry instruction word register. It round-robins two instruction sources into the register, manages write_pointer and read_pointer as a circular queue, and presents stored entries to the execution stage over a valid/ready handshake. Divide-by-zero instructions are screened out at load time and never reach the register.

## Interface
Parameters:
- DEPTH, 32, number of instruction register entries (power of two)
- PTR_W, $clog2(DEPTH) = 5, pointer width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req0_valid  in  1  requester 0 has an instruction
- req0_ready  out  1  requester 0 instruction accepted this cycle
- req0_opcode  in  opcode_t (4)  requester 0 opcode (PASSa, PASSb, ADD, SUB, MULT, DIV, MOD)
- req0_operand_a / req0_operand_b  in  32 signed  requester 0 operands
- req1_valid, req1_ready, req1_opcode, req1_operand_a, req1_operand_b  same as requester 0
- flush  in  1  synchronous queue clear
- load_en  out  1  register write strobe
- write_pointer  out  PTR_W  register write address
- opcode, operand_a, operand_b  out  4/32/32  write data to register
- read_pointer  out  PTR_W  register read address (head of queue)
- exec_valid  out  1  entry at read_pointer is available
- exec_ready  in  1  execution stage consumes head entry
- count  out  PTR_W+1  occupied entries, 0..DEPTH
- dz_error  out  1  one-cycle pulse: divide-by-zero instruction dropped
- dz_count  out  8  saturating count of dropped instructions

## Operation
- Grant: if one valid, grant it; if both valid, grant requester not in last_grant; last_grant resets to 1 (requester 0 wins first contest).
- reqN_ready = granted N AND count < DEPTH AND NOT flush AND NOT reset; at most one ready high per cycle.
- Handshake (valid&ready) updates last_grant, whether or not the instruction is written.
- Write data path is combinational: opcode/operand_a/operand_b mux from granted requester; write_pointer = wr_ptr.
- Divide-by-zero: opcode DIV or MOD with operand_b == 0. Instruction accepted (ready high) but load_en = 0, wr_ptr/count unchanged; dz_error pulses next cycle; dz_count increments, saturating at 255.
- Valid non-DZ handshake: load_en = 1; wr_ptr wraps DEPTH-1 -> 0 at edge.
- exec_valid = count != 0 AND NOT flush; read_pointer = rd_ptr; exec_valid&exec_ready advances rd_ptr with wrap.
- count: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- Full (count == DEPTH): both readies 0 even if read occurs same cycle.
- flush: at edge, wr_ptr, rd_ptr, count = 0, last_grant = 1; dz_count and dz_error pipeline not cleared; no write or read handshake occurs in the flush cycle.

## Timing
- Reset values: wr_ptr 0, rd_ptr 0, count 0, last_grant 1, dz_error 0, dz_count 0; hence load_en 0, readies 0, exec_valid 0, write_pointer 0, read_pointer 0.
- Reset mid-operation: queue contents abandoned immediately (asynchronous), no handshake completes in a reset cycle.
- Load latency: instruction accepted at edge N is written into register at edge N; exec_valid high in cycle after N; read_pointer addresses it the same cycle.
- Throughput: one write and one read per cycle sustained.
- dz_error asserted exactly one cycle, the cycle after the dropping handshake; back-to-back DZ drops give consecutive pulses.
- count, pointers, dz_count are registered; readies, load_en, write data, exec_valid are combinational from registered state plus current inputs.

## Test plan
- Reset: assert reset mid-cycle with count = 5 -> count, pointers, dz_count read 0 immediately; readies and exec_valid 0 until release.
- Single load/exec: req0 ADD a=7 b=3 -> load_en 1, write_pointer 0; next cycle exec_valid 1, read_pointer 0; exec_ready -> count 0, read_pointer 1.
- Arbitration: both valid for 4 cycles, exec_ready held 1 -> grants 0,1,0,1; entries 0..3 written in that order.
- Full: 32 loads with exec_ready 0 -> count 32, readies 0 while valid held; single read plus valid same cycle -> no write; next cycle write to wrapped slot 0.
- Divide-by-zero: req1 DIV b=0 -> req1_ready 1, load_en 0, count unchanged; dz_error 1 next cycle, dz_count 1; MOD b=0 x256 -> dz_count holds 255.
- Wrap/flush: 40 interleaved load/read pairs -> pointers wrap 31->0, count stays 1; flush -> count 0, exec_valid 0, dz_count retained.

Source files
------------

// File: rtl/instr_register_scheduler.sv
// instr_register_scheduler: round-robin write arbiter and circular-queue read sequencer for the instruction register; ports: clk, reset, req0/req1 valid/ready/opcode/operands, flush, load_en/write_pointer/write data, read_pointer, exec_valid/exec_ready, count, dz_error, dz_count
module instr_register_scheduler #(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [3:0]         req0_opcode,
  input  logic signed [31:0] req0_operand_a,
  input  logic signed [31:0] req0_operand_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [3:0]         req1_opcode,
  input  logic signed [31:0] req1_operand_a,
  input  logic signed [31:0] req1_operand_b,
  input  logic               flush,
  output logic               load_en,
  output logic [PTR_W-1:0]   write_pointer,
  output logic [3:0]         opcode,
  output logic signed [31:0] operand_a,
  output logic signed [31:0] operand_b,
  output logic [PTR_W-1:0]   read_pointer,
  output logic               exec_valid,
  input  logic               exec_ready,
  output logic [PTR_W:0]     count,
  output logic               dz_error,
  output logic [7:0]         dz_count
);
  localparam logic [3:0] DIV = 4'd5;
  localparam logic [3:0] MOD = 4'd6;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_last, r_dz_error;
  logic [7:0]       r_dz_count;
  logic             w_g0, w_g1, w_ok, w_hs, w_dz, w_rd;
  // r_last = 1 means requester 1 won last, so requester 0 wins the next contest
  assign w_g1 = req1_valid & (~req0_valid | ~r_last);
  assign w_g0 = req0_valid & ~w_g1;
  assign w_ok = (r_count != (PTR_W+1)'(DEPTH)) & ~flush & ~reset;
  assign req0_ready = w_g0 & w_ok;
  assign req1_ready = w_g1 & w_ok;
  assign w_hs = req0_ready | req1_ready;
  assign opcode = w_g1 ? req1_opcode : req0_opcode;
  assign operand_a = w_g1 ? req1_operand_a : req0_operand_a;
  assign operand_b = w_g1 ? req1_operand_b : req0_operand_b;
  assign w_dz = (opcode == DIV || opcode == MOD) && operand_b == 0;
  assign load_en = w_hs & ~w_dz;
  assign exec_valid = (r_count != 0) & ~flush;
  assign w_rd = exec_valid & exec_ready;
  assign write_pointer = r_wr_ptr;
  assign read_pointer = r_rd_ptr;
  assign count = r_count;
  assign dz_error = r_dz_error;
  assign dz_count = r_dz_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_last <= 1'b1;
      r_dz_error <= 1'b0;
      r_dz_count <= '0;
    end else begin
      // no handshake can happen during flush, so the dz pipeline drains naturally
      r_dz_error <= w_hs & w_dz;
      if (w_hs & w_dz & (r_dz_count != 8'hff)) r_dz_count <= r_dz_count + 8'd1;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count <= '0;
        r_last <= 1'b1;
      end else begin
        if (w_hs) r_last <= w_g1;
        r_wr_ptr <= r_wr_ptr + PTR_W'(load_en);
        r_rd_ptr <= r_rd_ptr + PTR_W'(w_rd);
        r_count <= r_count + (PTR_W+1)'(load_en) - (PTR_W+1)'(w_rd);
      end
    end
endmodule

// File: tb/tb_instr_register_scheduler.sv
// tb_instr_register_scheduler: directed self-checking bench for instr_register_scheduler
module tb_instr_register_scheduler;
  localparam logic [3:0] PASSA = 4'd0, SUB = 4'd3, ADD = 4'd2, DIV = 4'd5, MOD = 4'd6;
  logic clk = 0, reset = 1, flush = 0, exec_ready = 0;
  logic req0_valid = 0, req1_valid = 0;
  logic [3:0] req0_opcode = 0, req1_opcode = 0;
  logic signed [31:0] req0_operand_a = 0, req0_operand_b = 0, req1_operand_a = 0, req1_operand_b = 0;
  logic req0_ready, req1_ready, load_en, exec_valid, dz_error;
  logic [4:0] write_pointer, read_pointer;
  logic [3:0] opcode;
  logic signed [31:0] operand_a, operand_b;
  logic [5:0] count;
  logic [7:0] dz_count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  instr_register_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
    .flush(flush), .load_en(load_en), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .read_pointer(read_pointer), .exec_valid(exec_valid), .exec_ready(exec_ready),
    .count(count), .dz_error(dz_error), .dz_count(dz_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_flush();
    req0_valid = 0; req1_valid = 0; exec_ready = 0; flush = 1;
    tick();
    flush = 0;
  endtask
  initial begin
    req0_valid = 1; req0_opcode = ADD; req0_operand_a = 7; req0_operand_b = 3;
    #2;
    chk("rst_count", count, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_exec_valid", exec_valid, 0);
    chk("rst_load_en", load_en, 0);
    chk("rst_wp", write_pointer, 0);
    chk("rst_dz_count", dz_count, 0);
    @(negedge clk); reset = 0;
    #1;
    chk("single_ready0", req0_ready, 1);
    chk("single_load_en", load_en, 1);
    chk("single_wp", write_pointer, 0);
    chk("single_opcode", opcode, ADD);
    chk("single_opa", operand_a, 7);
    chk("single_opb", operand_b, 3);
    tick();
    req0_valid = 0; #1;
    chk("single_exec_valid", exec_valid, 1);
    chk("single_rp0", read_pointer, 0);
    chk("single_count1", count, 1);
    exec_ready = 1;
    tick();
    chk("single_count0", count, 0);
    chk("single_rp1", read_pointer, 1);
    chk("single_exec_valid0", exec_valid, 0);
    do_flush();
    req0_valid = 1; req0_opcode = PASSA; req0_operand_a = 10; req0_operand_b = 1;
    req1_valid = 1; req1_opcode = SUB; req1_operand_a = 20; req1_operand_b = 1;
    exec_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("arb_ready0", req0_ready, (i % 2) == 0);
      chk("arb_ready1", req1_ready, (i % 2) == 1);
      chk("arb_wp", write_pointer, i);
      chk("arb_opa", operand_a, (i % 2) ? 20 : 10);
      tick();
      chk("arb_count", count, 1);
    end
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("arb_drain_count", count, 0);
    chk("arb_drain_rp", read_pointer, 4);
    do_flush();
    req0_valid = 1; req0_opcode = ADD; req0_operand_b = 3;
    for (int i = 0; i < 32; i++) tick();
    chk("full_count", count, 32);
    chk("full_ready0", req0_ready, 0);
    chk("full_wp_wrap", write_pointer, 0);
    exec_ready = 1; #1;
    chk("full_rd_ready0", req0_ready, 0);
    chk("full_rd_load_en", load_en, 0);
    chk("full_rd_exec_valid", exec_valid, 1);
    tick();
    chk("full_after_rd_count", count, 31);
    chk("full_after_rd_rp", read_pointer, 1);
    exec_ready = 0; #1;
    chk("full_refill_ready0", req0_ready, 1);
    chk("full_refill_load_en", load_en, 1);
    chk("full_refill_wp", write_pointer, 0);
    tick();
    chk("full_refill_count", count, 32);
    do_flush();
    req1_valid = 1; req1_opcode = DIV; req1_operand_a = 9; req1_operand_b = 0; #1;
    chk("dz_ready1", req1_ready, 1);
    chk("dz_load_en", load_en, 0);
    chk("dz_err_pre", dz_error, 0);
    tick();
    req1_valid = 0; #1;
    chk("dz_err_pulse", dz_error, 1);
    chk("dz_count1", dz_count, 1);
    chk("dz_queue_count", count, 0);
    chk("dz_wp", write_pointer, 0);
    tick();
    chk("dz_err_clear", dz_error, 0);
    req1_valid = 1; req1_opcode = MOD;
    for (int i = 0; i < 256; i++) tick();
    chk("dz_err_b2b", dz_error, 1);
    chk("dz_sat", dz_count, 255);
    req1_valid = 0;
    tick();
    chk("dz_sat_hold", dz_count, 255);
    chk("dz_err_end", dz_error, 0);
    do_flush();
    req0_valid = 1; req0_opcode = ADD; req0_operand_b = 3;
    tick();
    chk("wrap_prime_count", count, 1);
    exec_ready = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("wrap_count", count, 1);
    end
    chk("wrap_wp", write_pointer, 9);
    chk("wrap_rp", read_pointer, 8);
    flush = 1; #1;
    chk("flush_exec_valid", exec_valid, 0);
    chk("flush_ready0", req0_ready, 0);
    chk("flush_load_en", load_en, 0);
    tick();
    flush = 0; req0_valid = 0; exec_ready = 0; #1;
    chk("flush_count", count, 0);
    chk("flush_exec_valid_after", exec_valid, 0);
    chk("flush_rp", read_pointer, 0);
    chk("flush_dz_kept", dz_count, 255);
    req0_valid = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_count5", count, 5);
    #2 reset = 1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_wp", write_pointer, 0);
    chk("mid_rst_rp", read_pointer, 0);
    chk("mid_rst_dz", dz_count, 0);
    chk("mid_rst_ready0", req0_ready, 0);
    chk("mid_rst_exec_valid", exec_valid, 0);
    tick();
    chk("mid_rst_hold_count", count, 0);
    chk("mid_rst_hold_ready0", req0_ready, 0);
    @(negedge clk); reset = 0; #1;
    chk("mid_rel_ready0", req0_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
